// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..MaxDataBits data, optional parity, 1/2 stop bits,
// majority-voted sampling, one-entry holding register with overrun and break reporting.
module uart_rx_cfg #(
    parameter int unsigned BitTicks    = 16,
    parameter int unsigned MaxDataBits = 9
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   rx_i,
    input  logic [3:0]             cfg_data_bits_i,
    input  logic                   cfg_parity_en_i,
    input  logic                   cfg_parity_type_i,
    input  logic                   cfg_two_stop_i,
    output logic [MaxDataBits-1:0] data_o,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   break_o
);

    localparam int unsigned TickW = $clog2(BitTicks);
    localparam int unsigned IdxW  = $clog2(MaxDataBits);
    localparam int unsigned Mid   = BitTicks / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_WAIT
    } state_e;

    state_e state_q, state_d;

    logic                   rx_meta, rxs, rxs_q;
    logic [TickW-1:0]       tick_q;
    logic [IdxW-1:0]        bit_idx_q;
    logic [1:0]             samp_q;
    logic [MaxDataBits-1:0] data_q;
    logic [3:0]             nbits_q;
    logic                   par_en_q, par_odd_q, two_stop_q;
    logic                   par_bit_q, perr_q, ferr_q;

    logic [3:0] nbits_c;
    logic       at_dec_c, at_end_c, maj_c, last_bit_c, is_break_c;
    logic       start_c, complete_c, brk_c;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    always_comb begin
        if (cfg_data_bits_i < 4'd5)                   nbits_c = 4'd5;
        else if (cfg_data_bits_i > 4'(MaxDataBits))   nbits_c = 4'(MaxDataBits);
        else                                          nbits_c = cfg_data_bits_i;
    end

    assign at_dec_c   = (tick_q == TickW'(Mid + 1));
    assign at_end_c   = (tick_q == TickW'(BitTicks - 1));
    assign maj_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign last_bit_c = (bit_idx_q == IdxW'(nbits_q - 4'd1));
    assign is_break_c = !maj_c && (data_q == '0) && !(par_en_q && par_bit_q);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_c    = 1'b0;
        complete_c = 1'b0;
        brk_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxs_q && !rxs) begin
                    state_d = START;
                    start_c = 1'b1;
                end
            end
            START: begin
                if (at_dec_c && maj_c) state_d = IDLE;
                else if (at_end_c)     state_d = DATA;
            end
            DATA: begin
                if (at_end_c && last_bit_c) state_d = par_en_q ? PARITY : STOP1;
            end
            PARITY: begin
                if (at_end_c) state_d = STOP1;
            end
            STOP1: begin
                if (at_dec_c && is_break_c) begin
                    state_d = BRK_WAIT;
                    brk_c   = 1'b1;
                end else if (at_dec_c && !two_stop_q) begin
                    state_d    = IDLE;
                    complete_c = 1'b1;
                end else if (at_end_c && two_stop_q) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (at_dec_c) begin
                    state_d    = IDLE;
                    complete_c = 1'b1;
                end
            end
            BRK_WAIT: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing, sampling and frame assembly
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tick_q     <= '0;
            bit_idx_q  <= '0;
            samp_q     <= 2'b11;
            data_q     <= '0;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (state_q == IDLE || state_d != state_q || at_end_c) tick_q <= '0;
            else                                                    tick_q <= tick_q + TickW'(1);

            if (tick_q == TickW'(Mid - 1)) samp_q[0] <= rxs;
            if (tick_q == TickW'(Mid))     samp_q[1] <= rxs;

            if (start_c) begin
                nbits_q    <= nbits_c;
                par_en_q   <= cfg_parity_en_i;
                par_odd_q  <= cfg_parity_type_i;
                two_stop_q <= cfg_two_stop_i;
                data_q     <= '0;
                bit_idx_q  <= '0;
                par_bit_q  <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end

            if (state_q == DATA) begin
                if (at_dec_c) data_q[bit_idx_q] <= maj_c;
                if (at_end_c) bit_idx_q <= bit_idx_q + IdxW'(1);
            end

            if (state_q == PARITY && at_dec_c) begin
                par_bit_q <= maj_c;
                perr_q    <= ((^data_q) ^ par_odd_q) != maj_c;
            end

            if ((state_q == STOP1 || state_q == STOP2) && at_dec_c && !maj_c) ferr_q <= 1'b1;
        end
    end

    // Holding register; the stop bit being decided this cycle folds into the framing flag
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            break_o   <= brk_c;
            if (complete_c) begin
                if (!data_valid_o || data_ready_i) begin
                    data_o       <= data_q;
                    parity_err_o <= perr_q;
                    frame_err_o  <= ferr_q | ~maj_c;
                    data_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (data_ready_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int unsigned BitTicks    = 16;
    localparam int unsigned MaxDataBits = 9;

    logic                   clk_i = 1'b0;
    logic                   arst_ni;
    logic                   rx_i;
    logic [3:0]             cfg_data_bits_i;
    logic                   cfg_parity_en_i;
    logic                   cfg_parity_type_i;
    logic                   cfg_two_stop_i;
    logic [MaxDataBits-1:0] data_o;
    logic                   data_valid_o;
    logic                   data_ready_i;
    logic                   parity_err_o;
    logic                   frame_err_o;
    logic                   overrun_o;
    logic                   break_o;

    uart_rx_cfg #(.BitTicks(BitTicks), .MaxDataBits(MaxDataBits)) dut (
        .clk_i             (clk_i),
        .arst_ni           (arst_ni),
        .rx_i              (rx_i),
        .cfg_data_bits_i   (cfg_data_bits_i),
        .cfg_parity_en_i   (cfg_parity_en_i),
        .cfg_parity_type_i (cfg_parity_type_i),
        .cfg_two_stop_i    (cfg_two_stop_i),
        .data_o            (data_o),
        .data_valid_o      (data_valid_o),
        .data_ready_i      (data_ready_i),
        .parity_err_o      (parity_err_o),
        .frame_err_o       (frame_err_o),
        .overrun_o         (overrun_o),
        .break_o           (break_o)
    );

    always #5 clk_i = ~clk_i;

    int          vectors     = 0;
    int          miscompares = 0;
    int          ovr_cnt     = 0;
    int          brk_cnt     = 0;
    int          rise_cnt    = 0;
    int          vrun        = 0;
    int          last_run    = 0;
    time         rise_t      = 0;
    logic        vprev       = 1'b0;
    logic [10:0] got_q[$];

    // Observer: accepted words {parity_err, frame_err, data}, pulse counts, valid run length
    always @(negedge clk_i) begin
        if (data_valid_o && !vprev) begin
            rise_t   <= $time;
            rise_cnt <= rise_cnt + 1;
        end
        vprev <= data_valid_o;
        if (data_valid_o) vrun <= vrun + 1;
        else begin
            if (vrun != 0) last_run <= vrun;
            vrun <= 0;
        end
        if (data_valid_o && data_ready_i) got_q.push_back({parity_err_o, frame_err_o, data_o});
        if (overrun_o) ovr_cnt <= ovr_cnt + 1;
        if (break_o)   brk_cnt <= brk_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic set_cfg(input int bits, input logic pen, input logic odd, input logic two);
        cfg_data_bits_i   = 4'(bits);
        cfg_parity_en_i   = pen;
        cfg_parity_type_i = odd;
        cfg_two_stop_i    = two;
    endtask

    task automatic send_bit(input logic b, input int glitch_at = -1);
        for (int i = 0; i < int'(BitTicks); i++) begin
            rx_i = (i == glitch_at) ? ~b : b;
            cyc();
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen, input logic pbit,
                              input logic s1, input logic s2, input logic two, input int gap,
                              input int glitch_bit = -1);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i], (i == glitch_bit) ? int'(BitTicks / 2) : -1);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        rx_i = 1'b1;
        cyc(gap);
    endtask

    function automatic int clamp_bits(input int c);
        if (c < 5) return 5;
        if (c > int'(MaxDataBits)) return int'(MaxDataBits);
        return c;
    endfunction

    // Correct parity bit: even -> XOR of the data bits, odd -> its inverse
    function automatic logic calc_par(input logic [8:0] d, input int nb, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        return p;
    endfunction

    task automatic expect_word(input string tag, input logic [10:0] exp);
        check({tag, "_count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() != 0) check(tag, 32'(got_q.pop_front()), 32'(exp));
        got_q.delete();
    endtask

    time         t0;
    int          r0, o0, b0, nb, cfgb;
    logic        p, pen, odd, two, s1, s2, pbit, is_brk, exp_perr, exp_ferr;
    logic [8:0]  d, mask;

    initial begin
        arst_ni      = 1'b0;
        rx_i         = 1'b1;
        data_ready_i = 1'b1;
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        cyc(3);
        check("rst_data",   32'(data_o),       32'd0);
        check("rst_valid",  32'(data_valid_o), 32'd0);
        check("rst_perr",   32'(parity_err_o), 32'd0);
        check("rst_ferr",   32'(frame_err_o),  32'd0);
        check("rst_ovr",    32'(overrun_o),    32'd0);
        check("rst_brk",    32'(break_o),      32'd0);
        arst_ni = 1'b1;
        cyc(5);

        // 8N1 0xA5: sync (2) + edge detect + 9 bits + 9 stop ticks + holding register
        t0 = $time;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        expect_word("a5_word", {2'b00, 9'h0A5});
        check("a5_latency", 32'(rise_t - t0), 32'd1573);
        check("a5_valid_len", 32'(last_run), 32'd1);

        // 7 data bits, odd parity, two stop bits
        set_cfg(7, 1'b1, 1'b1, 1'b1);
        p = calc_par(9'h035, 7, 1'b1);
        send_frame(9'h035, 7, 1'b1, p, 1'b1, 1'b1, 1'b1, 6);
        expect_word("7o2_ok", {2'b00, 9'h035});
        send_frame(9'h035, 7, 1'b1, ~p, 1'b1, 1'b1, 1'b1, 6);
        expect_word("7o2_parity", {2'b10, 9'h035});
        send_frame(9'h035, 7, 1'b1, p, 1'b1, 1'b0, 1'b1, 6);
        expect_word("7o2_stop2", {2'b01, 9'h035});

        // False start, then a frame with a one-cycle glitch mid-bit
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        r0   = rise_cnt;
        rx_i = 1'b0;
        cyc(4);
        rx_i = 1'b1;
        cyc(40);
        check("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
        check("glitch_no_word", 32'(got_q.size()), 32'd0);
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6, 3);
        expect_word("glitch_word", {2'b00, 9'h05A});

        // Overrun with consumer stalled
        data_ready_i = 1'b0;
        o0 = ovr_cnt;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        check("ovr_no_accept", 32'(got_q.size()), 32'd0);
        check("ovr_data_held", 32'(data_o), 32'h011);
        check("ovr_valid_held", 32'(data_valid_o), 32'd1);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        data_ready_i = 1'b1;
        cyc(1);
        check("ovr_valid_drop", 32'(data_valid_o), 32'd0);
        expect_word("ovr_word", {2'b00, 9'h011});
        send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        expect_word("after_ovr", {2'b00, 9'h033});

        // Break: line low for three frame times
        b0   = brk_cnt;
        r0   = rise_cnt;
        rx_i = 1'b0;
        cyc(3 * 10 * int'(BitTicks));
        rx_i = 1'b1;
        cyc(20);
        check("brk_pulses", 32'(brk_cnt - b0), 32'd1);
        check("brk_no_valid", 32'(rise_cnt - r0), 32'd0);
        send_frame(9'h07E, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        expect_word("after_brk", {2'b00, 9'h07E});

        // Reset during data bit 3 of 0xC3
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_i = 1'b0;
        cyc(8);
        arst_ni = 1'b0;
        #1;
        check("mid_rst_data",  32'(data_o),       32'd0);
        check("mid_rst_valid", 32'(data_valid_o), 32'd0);
        check("mid_rst_flags", 32'({parity_err_o, frame_err_o, overrun_o, break_o}), 32'd0);
        rx_i = 1'b1;
        cyc(3);
        arst_ni = 1'b1;
        cyc(5);
        check("mid_rst_no_word", 32'(got_q.size()), 32'd0);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        expect_word("after_rst", {2'b00, 9'h0C3});

        // Data length below minimum clamps to 5
        set_cfg(2, 1'b0, 1'b0, 1'b0);
        send_frame(9'h01F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        expect_word("clamp5", {2'b00, 9'h01F});

        // Randomized frames against the frame-level model
        for (int k = 0; k < 12; k++) begin
            cfgb = int'($urandom_range(0, 15));
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            two  = 1'($urandom_range(0, 1));
            nb   = clamp_bits(cfgb);
            mask = 9'((1 << nb) - 1);
            d    = ($urandom_range(0, 4) == 0) ? 9'h000 : (9'($urandom) & mask);
            pbit = calc_par(d, nb, odd) ^ (pen && ($urandom_range(0, 3) == 0));
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            is_brk   = !s1 && (d == 9'h000) && (!pen || !pbit);
            exp_perr = pen && (pbit != calc_par(d, nb, odd));
            exp_ferr = !s1 || (two && !s2);
            set_cfg(cfgb, pen, odd, two);
            b0 = brk_cnt;
            send_frame(d, nb, pen, pbit, s1, s2, two, 4 + int'($urandom_range(0, 8)));
            if (is_brk) begin
                check($sformatf("rnd%0d_brk", k), 32'(brk_cnt - b0), 32'd1);
                check($sformatf("rnd%0d_brk_noword", k), 32'(got_q.size()), 32'd0);
            end else begin
                check($sformatf("rnd%0d_nobrk", k), 32'(brk_cnt - b0), 32'd0);
                expect_word($sformatf("rnd%0d", k), {exp_perr, exp_ferr, d});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
